// File: rtl/tlc_pkg.sv
// Shared request identifiers and arbiter FSM state encodings.
// Also used by traffic_light_controller so both ends agree on req_id values.
package tlc_pkg;

    localparam int unsigned REQ_W = 2;

    localparam logic [REQ_W-1:0] REQ_NONE  = 2'd0;
    localparam logic [REQ_W-1:0] REQ_SIDE  = 2'd1;
    localparam logic [REQ_W-1:0] REQ_WALK  = 2'd2;
    localparam logic [REQ_W-1:0] REQ_EMERG = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OFFER   = 2'd1,
        ST_BUSY    = 2'd2,
        ST_HOLDOFF = 2'd3
    } arb_state_t;

endpackage

// File: rtl/input_debouncer.sv
// Two-flop synchronizer followed by a stable-count debouncer.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   i_async    - raw asynchronous field input
//   o_level    - debounced level
//   o_rise     - one-cycle pulse on the edge o_level goes 0->1
module input_debouncer #(
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned CNT_W      = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise
);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_rise;
    logic [CNT_W-1:0] r_cnt;

    // The level only follows the synchronized input after it has disagreed
    // for DEB_CYCLES consecutive cycles; any agreement restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_async;
            r_sync2 <= r_sync1;
            r_rise  <= 1'b0;
            if (r_sync2 != r_level) begin
                if (r_cnt == CNT_W'(DEB_CYCLES - 1)) begin
                    r_level <= r_sync2;
                    r_rise  <= r_sync2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;

endmodule

// File: rtl/crossing_request_arbiter.sv
// Arbitrates side-street, pedestrian and emergency requests and offers one at
// a time to the light controller over valid/ready, with svc_done closing it.
// Ports:
//   clk, rst, tick               - clock, sync active-high reset, timebase pulse
//   Sensor, WalkButton, Emergency- raw asynchronous field inputs
//   req_ready, svc_done          - controller handshake inputs
//   req_valid, req_id            - offered request and its id
//   preempt                      - emergency waiting behind a normal service
//   side_pending, walk_pending   - latched requests
//   busy                         - a granted service is in progress
module crossing_request_arbiter
    import tlc_pkg::*;
#(
    parameter int unsigned DEB_CYCLES    = 4,
    parameter int unsigned HOLDOFF_TICKS = 5,
    parameter int unsigned CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       Sensor,
    input  logic       WalkButton,
    input  logic       Emergency,
    input  logic       req_ready,
    input  logic       svc_done,
    output logic       req_valid,
    output logic [1:0] req_id,
    output logic       preempt,
    output logic       side_pending,
    output logic       walk_pending,
    output logic       busy
);

    logic w_sensor, w_sensor_rise;
    logic w_walk, w_walk_rise;
    logic w_emerg, w_emerg_rise;
    logic w_unused_rise;

    arb_state_t       r_state, w_state_nx;
    logic [1:0]       r_req_id, w_req_id_nx, w_pick;
    logic [CNT_W-1:0] r_hold_cnt, w_hold_cnt_nx;
    logic             r_last_walk, w_last_walk_nx;
    logic             r_side_pend, w_side_pend_nx;
    logic             r_walk_pend, w_walk_pend_nx;
    logic             r_req_valid, r_busy, r_preempt;
    logic             w_accept;

    input_debouncer #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_sensor (
        .clk(clk), .rst(rst), .i_async(Sensor), .o_level(w_sensor), .o_rise(w_sensor_rise)
    );
    input_debouncer #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_walk (
        .clk(clk), .rst(rst), .i_async(WalkButton), .o_level(w_walk), .o_rise(w_walk_rise)
    );
    input_debouncer #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_emerg (
        .clk(clk), .rst(rst), .i_async(Emergency), .o_level(w_emerg), .o_rise(w_emerg_rise)
    );

    // Only the walk edge matters; sensor and emergency are level requests.
    assign w_unused_rise = w_sensor_rise ^ w_emerg_rise ^ w_walk;

    // Handshake completes only once the offer is actually visible.
    assign w_accept = (r_state == ST_OFFER) && r_req_valid && req_ready;

    // Next-state, request selection and latch updates.
    always_comb begin
        w_state_nx     = r_state;
        w_req_id_nx    = r_req_id;
        w_hold_cnt_nx  = r_hold_cnt;
        w_last_walk_nx = r_last_walk;
        w_side_pend_nx = r_side_pend;
        w_walk_pend_nx = r_walk_pend;
        w_pick         = REQ_NONE;

        // Emergency first; otherwise alternate away from the last served.
        if (w_emerg) begin
            w_pick = REQ_EMERG;
        end else if (r_side_pend && r_walk_pend) begin
            w_pick = r_last_walk ? REQ_SIDE : REQ_WALK;
        end else if (r_side_pend) begin
            w_pick = REQ_SIDE;
        end else if (r_walk_pend) begin
            w_pick = REQ_WALK;
        end

        case (r_state)
            ST_IDLE: begin
                if (w_pick != REQ_NONE) begin
                    w_state_nx  = ST_OFFER;
                    w_req_id_nx = w_pick;
                end
            end
            ST_OFFER: begin
                if (w_accept) begin
                    w_state_nx = ST_BUSY;
                    if (r_req_id == REQ_SIDE) w_last_walk_nx = 1'b0;
                    if (r_req_id == REQ_WALK) w_last_walk_nx = 1'b1;
                end
            end
            ST_BUSY: begin
                if (svc_done) begin
                    w_req_id_nx = REQ_NONE;
                    if (r_req_id == REQ_EMERG) begin
                        w_state_nx = ST_IDLE;
                    end else begin
                        w_state_nx    = ST_HOLDOFF;
                        w_hold_cnt_nx = CNT_W'(HOLDOFF_TICKS);
                    end
                end
            end
            ST_HOLDOFF: begin
                if (w_emerg) begin
                    w_state_nx  = ST_OFFER;
                    w_req_id_nx = REQ_EMERG;
                end else if (tick) begin
                    if (r_hold_cnt <= CNT_W'(1)) begin
                        w_state_nx    = ST_IDLE;
                        w_hold_cnt_nx = '0;
                    end else begin
                        w_hold_cnt_nx = r_hold_cnt - CNT_W'(1);
                    end
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase

        // A held Sensor must not re-request the service it is already getting.
        if (w_accept && (r_req_id == REQ_SIDE)) begin
            w_side_pend_nx = 1'b0;
        end else if (w_sensor && !((r_state == ST_BUSY) && (r_req_id == REQ_SIDE))) begin
            w_side_pend_nx = 1'b1;
        end

        // A fresh press in the accept cycle survives the clear.
        if (w_accept && (r_req_id == REQ_WALK)) w_walk_pend_nx = 1'b0;
        if (w_walk_rise)                        w_walk_pend_nx = 1'b1;
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_req_id    <= REQ_NONE;
            r_hold_cnt  <= '0;
            r_last_walk <= 1'b1;
            r_side_pend <= 1'b0;
            r_walk_pend <= 1'b0;
            r_req_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_preempt   <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_req_id    <= w_req_id_nx;
            r_hold_cnt  <= w_hold_cnt_nx;
            r_last_walk <= w_last_walk_nx;
            r_side_pend <= w_side_pend_nx;
            r_walk_pend <= w_walk_pend_nx;
            // Offer becomes visible one cycle after entering OFFER.
            r_req_valid <= (r_state == ST_OFFER) && (w_state_nx == ST_OFFER);
            r_busy      <= (w_state_nx == ST_BUSY);
            r_preempt   <= (w_state_nx == ST_BUSY) && (w_req_id_nx != REQ_EMERG) && w_emerg;
        end
    end

    assign req_valid    = r_req_valid;
    assign req_id       = r_req_id;
    assign preempt      = r_preempt;
    assign side_pending = r_side_pend;
    assign walk_pending = r_walk_pend;
    assign busy         = r_busy;

endmodule

// File: tb/tb_crossing_request_arbiter.sv
// Scoreboard bench for crossing_request_arbiter.
module tb_crossing_request_arbiter;

    localparam int unsigned DEB  = 4;
    localparam int unsigned HOLD = 5;
    localparam int unsigned TPER = 4;
    localparam int          N_RAND = 14;

    logic       clk = 1'b0;
    logic       rst, tick, Sensor, WalkButton, Emergency, req_ready, svc_done;
    logic       req_valid, preempt, side_pending, walk_pending, busy;
    logic [1:0] req_id;

    crossing_request_arbiter #(.DEB_CYCLES(DEB), .HOLDOFF_TICKS(HOLD), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .tick(tick), .Sensor(Sensor), .WalkButton(WalkButton),
        .Emergency(Emergency), .req_ready(req_ready), .svc_done(svc_done),
        .req_valid(req_valid), .req_id(req_id), .preempt(preempt),
        .side_pending(side_pending), .walk_pending(walk_pending), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];
    bit hold_expect = 1'b0;
    int tick_seen   = 0;

    // Reference model: which requests are outstanding and who was served last.
    bit m_side, m_walk, m_last_walk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input bit s, input bit w, input bit last_walk);
        if (s && w) return last_walk ? 1 : 2;
        if (s) return 1;
        return 2;
    endfunction

    // Timebase: one-cycle tick every TPER cycles.
    initial begin
        tick = 1'b0;
        forever begin
            repeat (TPER - 1) @(posedge clk);
            #1 tick = 1'b1;
            @(posedge clk);
            #1 tick = 1'b0;
        end
    end

    // Monitor: checks every accepted offer and the hold-off tick count.
    initial begin : monitor
        bit prev_valid;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_valid = 1'b0;
            end else begin
                if (svc_done) tick_seen = 0;
                else if (tick) tick_seen++;
                if (req_valid && !prev_valid && hold_expect) begin
                    check("holdoff_ticks", tick_seen, HOLD);
                    hold_expect = 1'b0;
                end
                if (req_valid && req_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL stray_offer: req_id %0d accepted, nothing expected", req_id);
                    end else begin
                        check("offer_id", int'(req_id), exp_q.pop_front());
                    end
                end
                prev_valid = req_valid;
            end
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: cycle budget exhausted");
        $fatal(1, "watchdog");
    end

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (req_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_valid: no offer within %0d cycles", budget);
        end
    endtask

    // Controller side: accept the offer after a random delay.
    task automatic accept();
        bit ok;
        wait_valid(400, ok);
        if (ok) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            @(posedge clk);
            #1 req_ready = 1'b1;
            @(posedge clk);
            #1 req_ready = 1'b0;
        end
    endtask

    task automatic finish_service(input int cycles);
        repeat (cycles) @(posedge clk);
        #1 svc_done = 1'b1;
        @(posedge clk);
        #1 svc_done = 1'b0;
    endtask

    task automatic press_walk(input int len);
        WalkButton = 1'b1;
        repeat (len) @(posedge clk);
        #1 WalkButton = 1'b0;
    endtask

    // Offer latency from a quiet IDLE: valid exactly DEB+4 cycles after first sample.
    task automatic check_latency(input string name);
        repeat (DEB + 4) @(posedge clk);
        @(negedge clk);
        check({name, "_early"}, int'(req_valid), 0);
        @(posedge clk);
        @(negedge clk);
        check({name, "_valid"}, int'(req_valid), 1);
    endtask

    // One service round: predict, accept, optionally inject an emergency.
    task automatic serve_round(input bit keep_sensor, input bit inj, input bit hold_after);
        int e;
        e = pick(m_side, m_walk, m_last_walk);
        exp_q.push_back(e);
        accept();
        if (e == 1) begin
            m_last_walk = 1'b0;
            if (!keep_sensor) begin
                Sensor = 1'b0;
                m_side = 1'b0;
            end
        end else begin
            m_last_walk = 1'b1;
            m_walk      = 1'b0;
        end
        if (inj) begin
            Emergency = 1'b1;
            repeat (DEB + 4) @(posedge clk);
            @(negedge clk);
            check("preempt", int'(preempt), 1);
            exp_q.push_back(3);
            finish_service(1);
            accept();
            Emergency = 1'b0;
            finish_service(10);
        end else begin
            finish_service($urandom_range(8, 14));
            hold_expect = hold_after;
        end
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_req_valid"}, int'(req_valid), 0);
        check({name, "_req_id"}, int'(req_id), 0);
        check({name, "_preempt"}, int'(preempt), 0);
        check({name, "_side_pending"}, int'(side_pending), 0);
        check({name, "_walk_pending"}, int'(walk_pending), 0);
        check({name, "_busy"}, int'(busy), 0);
    endtask

    initial begin
        bit ok;
        int seen;
        bit add_s, add_w, keep, inj;

        rst = 1'b1; Sensor = 1'b0; WalkButton = 1'b0; Emergency = 1'b0;
        req_ready = 1'b0; svc_done = 1'b0;
        m_side = 1'b0; m_walk = 1'b0; m_last_walk = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset");

        // Side request latency and accept behaviour.
        @(posedge clk);
        #1 Sensor = 1'b1;
        m_side = 1'b1;
        check_latency("side_latency");
        check("side_first_id", int'(req_id), 1);
        exp_q.push_back(1);
        accept();
        Sensor = 1'b0;
        m_side = 1'b0;
        m_last_walk = 1'b0;
        @(negedge clk);
        check("accept_side_pending", int'(side_pending), 0);
        check("accept_busy", int'(busy), 1);
        check("accept_valid_drop", int'(req_valid), 0);
        finish_service(10);
        repeat (40) @(posedge clk);

        // Walk glitch ignored; real press latched.
        #1 press_walk(3);
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("glitch_walk_pending", int'(walk_pending), 0);
        check("glitch_no_offer", int'(req_valid), 0);
        @(posedge clk);
        #1 press_walk(6);
        m_walk = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("press_walk_pending", int'(walk_pending), 1);
        serve_round(1'b0, 1'b0, 1'b0);
        repeat (40) @(posedge clk);

        // Both requests together: alternation 1,2,1 with hold-off between.
        #1 Sensor = 1'b1;
        m_side = 1'b1;
        press_walk(6);
        m_walk = 1'b1;
        serve_round(1'b1, 1'b0, 1'b1);
        serve_round(1'b1, 1'b0, 1'b1);
        serve_round(1'b0, 1'b0, 1'b0);
        repeat (40) @(posedge clk);

        // Emergency while busy with SIDE; EMERG completion skips hold-off.
        #1 Sensor = 1'b1;
        m_side = 1'b1;
        serve_round(1'b0, 1'b1, 1'b0);
        check("emerg_done_busy", int'(busy), 0);
        Sensor = 1'b1;
        m_side = 1'b1;
        check_latency("no_holdoff_latency");
        serve_round(1'b0, 1'b0, 1'b0);

        // Emergency aborts hold-off with 3 ticks remaining.
        seen = 0;
        for (int i = 0; i < 40 && seen < 2; i++) begin
            @(negedge clk);
            if (tick) seen++;
        end
        check("holdoff_two_ticks", seen, 2);
        @(posedge clk);
        #1 Emergency = 1'b1;
        exp_q.push_back(3);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (req_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check("emerg_abort_fast", int'(ok), 1);
        accept();
        Emergency = 1'b0;
        finish_service(10);
        repeat (5) @(posedge clk);

        // Reset in the middle of a WALK offer.
        #1 press_walk(6);
        wait_valid(40, ok);
        check("offer_walk_id", int'(req_id), 2);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        m_side = 1'b0; m_walk = 1'b0; m_last_walk = 1'b1;
        @(negedge clk);
        check_idle_outputs("midreset");
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (req_valid || walk_pending || side_pending) seen++;
        end
        check("no_request_after_reset", seen, 0);

        // Randomized rounds against the model.
        for (int r = 0; r < N_RAND; r++) begin
            @(posedge clk);
            #1;
            add_s = 1'($urandom_range(0, 1));
            add_w = 1'($urandom_range(0, 1));
            if (!m_side && !m_walk && !add_s && !add_w) add_s = 1'b1;
            if (add_s && !m_side) begin
                Sensor = 1'b1;
                m_side = 1'b1;
            end
            if (add_w && !m_walk) begin
                press_walk($urandom_range(5, 8));
                m_walk = 1'b1;
            end
            keep = ($urandom_range(0, 3) == 0);
            inj  = ($urandom_range(0, 3) == 0);
            serve_round(keep, inj, (r < N_RAND - 1) && !inj);
        end
        for (int i = 0; i < 3 && (m_side || m_walk); i++) begin
            serve_round(1'b0, 1'b0, 1'b0);
        end
        repeat (40) @(posedge clk);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
